// File: rtl/nios_project_irq_pkg.sv
// rtl/nios_project_irq_pkg.sv - shared constants for the Nios interrupt controller
package nios_project_irq_pkg;

  localparam int MAX_IRQ          = 16;
  localparam int VECTOR_VALID_BIT = 15;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_ACK     = 3'd5;
  localparam logic [2:0] ADDR_FORCE   = 3'd6;

endpackage

// File: rtl/nios_project_irq_prio_enc.sv
// rtl/nios_project_irq_prio_enc.sv - priority encoder, lowest active index wins
module nios_project_irq_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] active,
  output logic               valid,
  output logic [3:0]         id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        valid = 1'b1;
        id    = i[3:0];
      end
    end
  end

endmodule

// File: rtl/nios_project_irq_ctrl.sv
// rtl/nios_project_irq_ctrl.sv - Avalon-MM interrupt controller with level/edge capture and vector
module nios_project_irq_ctrl
  import nios_project_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               chipselect,
  input  logic [2:0]         address,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  localparam logic [31:0]        IMPL_W = (32'h1 << NUM_IRQ) - 32'h1;
  localparam logic [MAX_IRQ-1:0] IMPL   = IMPL_W[MAX_IRQ-1:0];

  logic [NUM_IRQ-1:0] s_in;
  logic [MAX_IRQ-1:0] s_ext;
  logic [MAX_IRQ-1:0] pending_q, pending_d, mask_q, mask_d;
  logic [MAX_IRQ-1:0] edge_q, edge_d, prev_q, prev_d;
  logic [MAX_IRQ-1:0] set_v, clr_v, edge_next;
  logic [15:0]        readdata_q, readdata_d;
  logic               irq_q, irq_d;
  logic               wr_en;
  logic               vec_valid;
  logic [3:0]         vec_id;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s_in = irq_in;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
      logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = irq_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_d[s] = sync_q[s-1];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
        end
      end

      assign s_in = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  nios_project_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .active (pending_q[NUM_IRQ-1:0] & mask_q[NUM_IRQ-1:0]),
    .valid  (vec_valid),
    .id     (vec_id)
  );

  always_comb begin
    s_ext              = '0;
    s_ext[NUM_IRQ-1:0] = s_in;
  end

  always_comb begin
    wr_en  = chipselect && !write_n;
    mask_d = mask_q;
    edge_d = edge_q;
    set_v  = s_ext & ~prev_q;
    clr_v  = '0;
    if (wr_en) begin
      case (address)
        ADDR_PENDING: clr_v  = writedata;
        ADDR_MASK:    mask_d = writedata & IMPL;
        ADDR_EDGE:    edge_d = writedata & IMPL;
        ADDR_ACK:     clr_v  = 16'h0001 << writedata[3:0];
        ADDR_FORCE:   set_v  = set_v | writedata;
        default:      ;
      endcase
    end
    // Set is applied after clear so a same-cycle edge is never lost.
    edge_next = (pending_q & ~(clr_v & edge_q)) | (set_v & edge_q);
    pending_d = IMPL & ((edge_q & edge_next) | (~edge_q & s_ext));
    prev_d    = s_ext;
    irq_d     = |(pending_q & mask_q);

    readdata_d = '0;
    case (address)
      ADDR_STATUS:  readdata_d = s_ext;
      ADDR_PENDING: readdata_d = pending_q;
      ADDR_MASK:    readdata_d = mask_q;
      ADDR_EDGE:    readdata_d = edge_q;
      ADDR_VECTOR: begin
        readdata_d[VECTOR_VALID_BIT] = vec_valid;
        readdata_d[3:0]              = vec_id;
      end
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      prev_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      prev_q     <= prev_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_project_irq_ctrl.sv
// tb/tb_nios_project_irq_ctrl.sv - scoreboard bench for nios_project_irq_ctrl
module tb_nios_project_irq_ctrl;
  import nios_project_irq_pkg::*;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          chipselect = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = 16'h0;
  logic [15:0]   readdata;
  logic [N-1:0]  irq_in = '0;
  logic          irq;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  logic rd_strobe = 1'b0, irq_strobe = 1'b0;
  logic rd_valid = 1'b0, irq_valid = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  nios_project_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    rd_valid  <= rd_strobe;
    irq_valid <= irq_strobe;
  end

  // Monitor: one pop per presented response.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (rd_q.size() == 0) check("rd_underflow", 16'd1, 16'd0);
      else begin
        e = rd_q.pop_front();
        check(e.name, readdata, e.exp);
      end
    end
    if (irq_valid) begin
      if (irq_q.size() == 0) check("irq_underflow", 16'd1, 16'd0);
      else begin
        e = irq_q.pop_front();
        check(e.name, {15'd0, irq}, e.exp);
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; rd_strobe = 1'b0; irq_strobe = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    rd_strobe = 1'b0; irq_strobe = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    rd_strobe = 1'b1; irq_strobe = 1'b0;
    e.exp = exp; e.name = name;
    rd_q.push_back(e);
  endtask

  // Checks irq right after the edge that ends the current cycle.
  task automatic chk_irq(input logic exp, input string name);
    exp_t e;
    irq_strobe = 1'b1;
    e.exp = {15'd0, exp}; e.name = name;
    irq_q.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 16'h0000, $sformatf("reset_rd_a%0d", a));
      if (a == 0) chk_irq(1'b0, "reset_irq");
    end

    // Edge capture on source 0, then W1C.
    wr(ADDR_EDGE, 16'h0001);
    wr(ADDR_MASK, 16'h0001);
    idle(); irq_in = 8'h01;
    rd(ADDR_PENDING, 16'h0001, "edge0_pending"); irq_in = 8'h00; chk_irq(1'b1, "edge0_irq");
    wr(ADDR_PENDING, 16'h0001); chk_irq(1'b1, "edge0_irq_hold");
    idle(); chk_irq(1'b0, "edge0_irq_clr");
    rd(ADDR_PENDING, 16'h0000, "edge0_pending_clr");

    // Priority vector and ACK.
    wr(ADDR_MASK, 16'h00FF);
    wr(ADDR_EDGE, 16'h00FF);
    idle(); irq_in = 8'h24;
    rd(ADDR_VECTOR, 16'h8002, "vec_2");
    wr(ADDR_ACK, 16'h0002);
    rd(ADDR_VECTOR, 16'h8005, "vec_5"); chk_irq(1'b1, "vec_irq");
    wr(ADDR_ACK, 16'h0009);
    rd(ADDR_PENDING, 16'h0020, "ack_out_of_range");
    wr(ADDR_ACK, 16'h0005);
    rd(ADDR_VECTOR, 16'h0000, "vec_none"); chk_irq(1'b0, "vec_irq_clr");
    rd(ADDR_STATUS, 16'h0024, "status");
    idle(); irq_in = 8'h00;

    // Level mode on source 3.
    wr(ADDR_EDGE, 16'h0000);
    wr(ADDR_MASK, 16'h0008);
    idle(); irq_in = 8'h08;
    wr(ADDR_PENDING, 16'h0008);
    rd(ADDR_PENDING, 16'h0008, "level_w1c_ignored"); chk_irq(1'b1, "level_irq");
    idle(); irq_in = 8'h00; chk_irq(1'b1, "level_irq_hold");
    rd(ADDR_PENDING, 16'h0000, "level_pending_drop"); chk_irq(1'b0, "level_irq_drop");

    // Same-cycle rising edge and W1C on source 1.
    wr(ADDR_EDGE, 16'h0002);
    wr(ADDR_MASK, 16'h0002);
    wr(ADDR_PENDING, 16'h0002); irq_in = 8'h02;
    rd(ADDR_PENDING, 16'h0002, "set_wins");
    wr(ADDR_PENDING, 16'h0002);
    rd(ADDR_PENDING, 16'h0000, "w1c_after");
    idle(); irq_in = 8'h00;

    // FORCE, then asynchronous reset.
    wr(ADDR_EDGE, 16'h0010);
    wr(ADDR_MASK, 16'h0010);
    wr(ADDR_FORCE, 16'h0011);
    idle(); chk_irq(1'b1, "force_irq");
    rd(ADDR_PENDING, 16'h0010, "force_pending");
    idle();
    idle();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 16'h0000);
    check("async_rst_irq", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    rd(ADDR_PENDING, 16'h0000, "post_rst_pending");
    rd(ADDR_MASK, 16'h0000, "post_rst_mask");
    idle(); chk_irq(1'b0, "post_rst_irq");
    idle();
    idle();
    check("drain", 16'(rd_q.size() + irq_q.size()), 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
